// File: rtl/pakrv_loader_pkg.sv
// pakrv_loader_pkg: shared state encoding and word geometry for the instruction-memory loader.
package pakrv_loader_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE, ST_ERROR} loader_state_e;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: packs handshaked bytes little-endian into a 32-bit word.
module loader_word_assembler
    import pakrv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        clr_i,
    input  logic        hs_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    always_comb begin
        byte_cnt_d = clr_i ? 2'd0 : hs_i ? byte_cnt_q + 2'd1 : byte_cnt_q;
        word_d = word_q;
        if (hs_i) word_d[{byte_cnt_q, 3'b000} +: 8] = data_i;
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            byte_cnt_q <= '0;
            word_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q <= word_d;
        end
    end
    assign word_o = word_q;
    assign word_done_o = hs_i && byte_cnt_q == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams bytes into instruction memory and holds the core
// in reset until the requested word count is written; stalled loads time out.
module imem_loader
    import pakrv_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("imem_loader: DATA_WIDTH must be 32");
    end
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   nwords_q, nwords_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  hs, clr, word_done;
    logic [31:0]           word;
    assign hs = s_ready && s_valid;
    loader_word_assembler u_asm (
        .clk         (clk),
        .arst        (arst),
        .clr_i       (clr),
        .hs_i        (hs),
        .data_i      (s_data),
        .word_o      (word),
        .word_done_o (word_done)
    );
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        nwords_d = nwords_q;
        idle_d = idle_q;
        clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
                nwords_d = num_words;
                addr_d = '0;
                idle_d = '0;
                clr = 1'b1;
                state_d = num_words == '0 ? ST_DONE : num_words > CAPACITY ? ST_ERROR : ST_LOAD;
            end
            ST_LOAD: if (hs) begin
                idle_d = '0;
                if (word_done) state_d = ST_WRITE;
            end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ERROR;
            end else begin
                idle_d = idle_q + IW'(1);
            end
            ST_WRITE: begin
                idle_d = '0;
                // Last word stops the address so a full-capacity load never wraps.
                if ({1'b0, addr_q} == nwords_q - (ADDR_WIDTH + 1)'(1)) state_d = ST_DONE;
                else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            nwords_q <= '0;
            idle_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            nwords_q <= nwords_d;
            idle_q <= idle_d;
        end
    end
    assign s_ready = state_q == ST_LOAD;
    assign mem_we = state_q == ST_WRITE;
    assign mem_addr = addr_q;
    assign mem_wdata = word;
    assign core_rst = state_q != ST_DONE;
    assign busy = state_q == ST_LOAD || state_q == ST_WRITE;
    assign done = state_q == ST_DONE;
    assign error = state_q == ST_ERROR;
endmodule
